// File: rtl/id_ex_register_if.sv
// rtl/id_ex_register_if.sv - ID/EX pipeline register control, payload and status bundle
interface id_ex_register_if;
    logic        hold_i;
    logic        flush_i;
    logic        stall_i;
    logic        clr_cnt_i;
    logic [7:0]  ctrl_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic [31:0] imm_i;
    logic [4:0]  rs_addr_i;
    logic [4:0]  rt_addr_i;
    logic [4:0]  rd_addr_i;

    logic [7:0]  ctrl_o;
    logic [31:0] rs_data_o;
    logic [31:0] rt_data_o;
    logic [31:0] imm_o;
    logic [4:0]  rs_addr_o;
    logic [4:0]  rt_addr_o;
    logic [4:0]  rd_addr_o;
    logic        mem_read_o;
    logic        valid_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    modport slave (
        input  hold_i, flush_i, stall_i, clr_cnt_i,
        input  ctrl_i, rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i,
        output ctrl_o, rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o,
        output mem_read_o, valid_o, stall_cnt_o, flush_cnt_o
    );

    modport master (
        output hold_i, flush_i, stall_i, clr_cnt_i,
        output ctrl_i, rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i,
        input  ctrl_o, rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o,
        input  mem_read_o, valid_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with hold/flush/stall bubbles and event counters
module id_ex_register (
    input  logic              clk_i,
    input  logic              rst_i,
    id_ex_register_if.slave   bus
);
    logic [7:0]  ctrl_q,      ctrl_d;
    logic [31:0] rs_data_q,   rs_data_d;
    logic [31:0] rt_data_q,   rt_data_d;
    logic [31:0] imm_q,       imm_d;
    logic [4:0]  rs_addr_q,   rs_addr_d;
    logic [4:0]  rt_addr_q,   rt_addr_d;
    logic [4:0]  rd_addr_q,   rd_addr_d;
    logic        valid_q,     valid_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Priority hold > flush > stall > load; a flush hides a simultaneous stall.
    always_comb begin
        ctrl_d      = ctrl_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rd_addr_d   = rd_addr_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!bus.hold_i) begin
            if (bus.flush_i || bus.stall_i) begin
                ctrl_d    = '0;
                rs_data_d = '0;
                rt_data_d = '0;
                imm_d     = '0;
                rs_addr_d = '0;
                rt_addr_d = '0;
                rd_addr_d = '0;
                valid_d   = 1'b0;
                if (bus.flush_i) flush_cnt_d = sat_inc(flush_cnt_q);
                else             stall_cnt_d = sat_inc(stall_cnt_q);
            end else begin
                ctrl_d    = bus.ctrl_i;
                rs_data_d = bus.rs_data_i;
                rt_data_d = bus.rt_data_i;
                imm_d     = bus.imm_i;
                rs_addr_d = bus.rs_addr_i;
                rt_addr_d = bus.rt_addr_i;
                rd_addr_d = bus.rd_addr_i;
                valid_d   = 1'b1;
            end
            // Clear wins over any increment taken on the same edge.
            if (bus.clr_cnt_i) begin
                stall_cnt_d = '0;
                flush_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q      <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_addr_q   <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rd_addr_q   <= rd_addr_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.ctrl_o      = ctrl_q;
    assign bus.rs_data_o   = rs_data_q;
    assign bus.rt_data_o   = rt_data_q;
    assign bus.imm_o       = imm_q;
    assign bus.rs_addr_o   = rs_addr_q;
    assign bus.rt_addr_o   = rt_addr_q;
    assign bus.rd_addr_o   = rd_addr_q;
    assign bus.valid_o     = valid_q;
    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;
    // MemRead for the hazard unit, taken straight from the registered control byte.
    assign bus.mem_read_o  = ctrl_q[5];
endmodule

// File: tb/tb_id_ex_register.sv
// tb/tb_id_ex_register.sv - directed self-checking bench for id_ex_register
module tb_id_ex_register;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   total = 0;
    int   bad   = 0;

    id_ex_register_if bus ();
    id_ex_register dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [7:0] c, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] im, input logic [4:0] ra, input logic [4:0] ta,
                         input logic [4:0] da);
        bus.ctrl_i    = c;
        bus.rs_data_i = rs;
        bus.rt_data_i = rt;
        bus.imm_i     = im;
        bus.rs_addr_i = ra;
        bus.rt_addr_i = ta;
        bus.rd_addr_i = da;
    endtask

    task automatic ctl(input logic h, input logic f, input logic s, input logic c);
        bus.hold_i    = h;
        bus.flush_i   = f;
        bus.stall_i   = s;
        bus.clr_cnt_i = c;
    endtask

    task automatic test_reset;
        ctl(0, 0, 0, 0);
        drive(8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 5'd31, 5'd31);
        #3;
        total++;
        if ({bus.ctrl_o, bus.rs_data_o, bus.rt_data_o, bus.imm_o} !== 104'd0) begin
            bad++; $display("FAIL reset_payload got=%h want=0", {bus.ctrl_o, bus.rs_data_o, bus.rt_data_o, bus.imm_o});
        end
        total++;
        if ({bus.rs_addr_o, bus.rt_addr_o, bus.rd_addr_o, bus.valid_o, bus.mem_read_o} !== 17'd0) begin
            bad++; $display("FAIL reset_addr_valid got=%h want=0", {bus.rs_addr_o, bus.rt_addr_o, bus.rd_addr_o, bus.valid_o, bus.mem_read_o});
        end
        step();
        total++;
        if ({bus.stall_cnt_o, bus.flush_cnt_o, bus.valid_o} !== 33'd0) begin
            bad++; $display("FAIL reset_counters got=%h want=0", {bus.stall_cnt_o, bus.flush_cnt_o, bus.valid_o});
        end
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_load;
        drive(8'hA5, 32'h1234_5678, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 5'd3, 5'd9, 5'd17);
        step();
        total++;
        if (bus.ctrl_o !== 8'hA5) begin bad++; $display("FAIL load_ctrl got=%h want=a5", bus.ctrl_o); end
        total++;
        if (bus.rs_data_o !== 32'h1234_5678) begin bad++; $display("FAIL load_rs_data got=%h want=12345678", bus.rs_data_o); end
        total++;
        if ({bus.rt_data_o, bus.imm_o} !== {32'hDEAD_BEEF, 32'hFFFF_FFF0}) begin
            bad++; $display("FAIL load_rt_imm got=%h want=deadbeeffffffff0", {bus.rt_data_o, bus.imm_o});
        end
        total++;
        if ({bus.rs_addr_o, bus.rt_addr_o, bus.rd_addr_o} !== {5'd3, 5'd9, 5'd17}) begin
            bad++; $display("FAIL load_addrs got=%0d,%0d,%0d want=3,9,17", bus.rs_addr_o, bus.rt_addr_o, bus.rd_addr_o);
        end
        total++;
        if ({bus.valid_o, bus.mem_read_o} !== 2'b11) begin
            bad++; $display("FAIL load_valid_memread got=%b want=11", {bus.valid_o, bus.mem_read_o});
        end
    endtask

    task automatic test_stall;
        ctl(0, 0, 1, 0);
        drive(8'h3C, 32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 5'd1, 5'd2, 5'd4);
        step();
        total++;
        if ({bus.ctrl_o, bus.rs_data_o, bus.rt_data_o, bus.imm_o, bus.rs_addr_o, bus.rt_addr_o, bus.rd_addr_o} !== 119'd0) begin
            bad++; $display("FAIL stall_bubble got ctrl=%h rs=%h rt=%h", bus.ctrl_o, bus.rs_data_o, bus.rt_data_o);
        end
        total++;
        if ({bus.valid_o, bus.stall_cnt_o, bus.flush_cnt_o} !== {1'b0, 16'd1, 16'd0}) begin
            bad++; $display("FAIL stall_count got valid=%b stall=%0d flush=%0d want 0,1,0", bus.valid_o, bus.stall_cnt_o, bus.flush_cnt_o);
        end
        ctl(0, 0, 0, 0);
        step();
        total++;
        if ({bus.ctrl_o, bus.rt_data_o, bus.rd_addr_o, bus.valid_o, bus.stall_cnt_o} !== {8'h3C, 32'h0000_2222, 5'd4, 1'b1, 16'd1}) begin
            bad++; $display("FAIL stall_release got ctrl=%h rt=%h rd=%0d valid=%b stall=%0d want 3c,2222,4,1,1",
                            bus.ctrl_o, bus.rt_data_o, bus.rd_addr_o, bus.valid_o, bus.stall_cnt_o);
        end
    endtask

    task automatic test_priority;
        ctl(1, 1, 1, 0);
        drive(8'hFF, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 5'd7, 5'd8, 5'd9);
        step();
        total++;
        if ({bus.ctrl_o, bus.rt_data_o, bus.valid_o, bus.stall_cnt_o, bus.flush_cnt_o} !== {8'h3C, 32'h0000_2222, 1'b1, 16'd1, 16'd0}) begin
            bad++; $display("FAIL prio_hold got ctrl=%h rt=%h valid=%b stall=%0d flush=%0d want 3c,2222,1,1,0",
                            bus.ctrl_o, bus.rt_data_o, bus.valid_o, bus.stall_cnt_o, bus.flush_cnt_o);
        end
        ctl(0, 1, 1, 0);
        step();
        total++;
        if ({bus.ctrl_o, bus.rs_data_o, bus.imm_o, bus.valid_o, bus.stall_cnt_o, bus.flush_cnt_o} !== {8'h00, 64'd0, 1'b0, 16'd1, 16'd1}) begin
            bad++; $display("FAIL prio_flush got ctrl=%h rs=%h valid=%b stall=%0d flush=%0d want 0,0,0,1,1",
                            bus.ctrl_o, bus.rs_data_o, bus.valid_o, bus.stall_cnt_o, bus.flush_cnt_o);
        end
    endtask

    task automatic test_load_use;
        ctl(0, 0, 0, 0);
        drive(8'h20, 32'h0000_00AA, 32'h0000_00BB, 32'h0000_0004, 5'd5, 5'd6, 5'd0);
        step();
        total++;
        if (bus.mem_read_o !== 1'b1) begin bad++; $display("FAIL loaduse_memread_set got=%b want=1", bus.mem_read_o); end
        ctl(0, 0, 1, 0);
        drive(8'h80, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 5'd6, 5'd7, 5'd8);
        step();
        total++;
        if ({bus.mem_read_o, bus.valid_o, bus.stall_cnt_o} !== {1'b0, 1'b0, 16'd2}) begin
            bad++; $display("FAIL loaduse_bubble got memread=%b valid=%b stall=%0d want 0,0,2", bus.mem_read_o, bus.valid_o, bus.stall_cnt_o);
        end
        ctl(0, 0, 0, 0);
        step();
        total++;
        if ({bus.mem_read_o, bus.valid_o, bus.ctrl_o} !== {1'b0, 1'b1, 8'h80}) begin
            bad++; $display("FAIL loaduse_after got memread=%b valid=%b ctrl=%h want 0,1,80", bus.mem_read_o, bus.valid_o, bus.ctrl_o);
        end
    endtask

    task automatic test_back_to_back;
        ctl(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({bus.valid_o, bus.ctrl_o, bus.stall_cnt_o} !== {1'b0, 8'h00, 16'(3 + i)}) begin
                bad++; $display("FAIL b2b_stall_%0d got valid=%b ctrl=%h stall=%0d want 0,0,%0d", i, bus.valid_o, bus.ctrl_o, bus.stall_cnt_o, 3 + i);
            end
        end
        ctl(1, 0, 1, 1);
        step();
        total++;
        if ({bus.stall_cnt_o, bus.flush_cnt_o} !== {16'd5, 16'd1}) begin
            bad++; $display("FAIL clr_during_hold got stall=%0d flush=%0d want 5,1", bus.stall_cnt_o, bus.flush_cnt_o);
        end
        ctl(0, 1, 0, 1);
        step();
        total++;
        if ({bus.stall_cnt_o, bus.flush_cnt_o, bus.valid_o} !== {16'd0, 16'd0, 1'b0}) begin
            bad++; $display("FAIL clr_with_flush got stall=%0d flush=%0d valid=%b want 0,0,0", bus.stall_cnt_o, bus.flush_cnt_o, bus.valid_o);
        end
    endtask

    task automatic test_saturation;
        ctl(0, 0, 1, 0);
        for (int i = 0; i < 65537; i++) @(posedge clk_i);
        #1;
        total++;
        if ({bus.stall_cnt_o, bus.flush_cnt_o} !== {16'hFFFF, 16'd0}) begin
            bad++; $display("FAIL sat_reach got stall=%h flush=%h want ffff,0", bus.stall_cnt_o, bus.flush_cnt_o);
        end
        step();
        total++;
        if (bus.stall_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", bus.stall_cnt_o); end
        ctl(0, 0, 1, 1);
        step();
        total++;
        if (bus.stall_cnt_o !== 16'd0) begin bad++; $display("FAIL sat_clear got=%h want=0", bus.stall_cnt_o); end
        ctl(0, 0, 0, 0);
    endtask

    task automatic test_async_reset;
        drive(8'h5A, 32'hCAFE_F00D, 32'h0BAD_0BAD, 32'h0000_0010, 5'd10, 5'd11, 5'd12);
        ctl(0, 1, 0, 0);
        step();
        ctl(0, 0, 0, 0);
        step();
        total++;
        if ({bus.ctrl_o, bus.valid_o, bus.flush_cnt_o} !== {8'h5A, 1'b1, 16'd1}) begin
            bad++; $display("FAIL areset_preload got ctrl=%h valid=%b flush=%0d want 5a,1,1", bus.ctrl_o, bus.valid_o, bus.flush_cnt_o);
        end
        #1 rst_i = 1'b0;
        #1;
        total++;
        if ({bus.ctrl_o, bus.rs_data_o, bus.rt_data_o, bus.imm_o, bus.rs_addr_o, bus.rt_addr_o, bus.rd_addr_o,
             bus.valid_o, bus.mem_read_o, bus.stall_cnt_o, bus.flush_cnt_o} !== 153'd0) begin
            bad++; $display("FAIL areset_immediate got ctrl=%h rs=%h valid=%b flush=%0d want all 0",
                            bus.ctrl_o, bus.rs_data_o, bus.valid_o, bus.flush_cnt_o);
        end
        #1 rst_i = 1'b1;
        drive(8'h11, 32'h0000_0042, 32'h0000_0043, 32'h0000_0044, 5'd13, 5'd14, 5'd15);
        step();
        total++;
        if ({bus.ctrl_o, bus.rs_data_o, bus.rd_addr_o, bus.valid_o, bus.flush_cnt_o} !== {8'h11, 32'h0000_0042, 5'd15, 1'b1, 16'd0}) begin
            bad++; $display("FAIL areset_release got ctrl=%h rs=%h rd=%0d valid=%b flush=%0d want 11,42,15,1,0",
                            bus.ctrl_o, bus.rs_data_o, bus.rd_addr_o, bus.valid_o, bus.flush_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_priority();
        test_load_use();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
